score_neighbour_fetch: RTL

Parametrised fetcher for the diag/up/left neighbour scores of one Needleman-Wunsch matrix cell (i,j). It takes a cell request, issues up to three pipelined reads to the score RAM, and synthesises row-0/column-0 boundary scores arithmetically instead of reading them. The three scores are presented to the cell-compute stage under a valid/ready handshake. It sits between the score RAM read port and the max/compare datapath, and supersedes fixed-width, fixed-latency neighbour buffering.

---
 rtl/score_neighbour_fetch.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/score_neighbour_fetch.sv
// Neighbour-score fetcher for one Needleman-Wunsch cell: issues diag/up/left RAM reads,
// synthesises row-0/column-0 scores arithmetically, and presents them under valid/ready.
module score_neighbour_fetch #(
  parameter int W = 9,
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int ADDR_W = 5,
  parameter int GAP = 1,
  parameter int RAM_LAT = 1,
  parameter logic [W-1:0] SENTINEL = W'(255)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [7:0]        req_i,
  input  logic [7:0]        req_j,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [W-1:0]      rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      diag,
  output logic [W-1:0]      up,
  output logic [W-1:0]      left,
  output logic              err
);

  // state | meaning
  // IDLE  | waiting for a cell request
  // ISSUE | one slot per cycle: 0=diag, 1=up, 2=left
  // WAIT  | RAM_LAT cycles for the last read to return
  // HOLD  | scores valid, held until consumer accepts
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  localparam int WC_W = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;

  state_t            state, state_nxt;
  logic [7:0]        cell_i, cell_j;
  logic [1:0]        slot;
  logic [WC_W-1:0]   wait_cnt;
  logic [W-1:0]      slot_buf [3];
  logic              tag_v    [RAM_LAT];
  logic [1:0]        tag_slot [RAM_LAT];

  logic              req_bad;
  logic [7:0]        nb_r, nb_c;
  logic              nb_boundary;
  logic [W-1:0]      nb_value;

  assign req_bad = (req_i == 8'd0) || (req_j == 8'd0) ||
                   (req_i > 8'(ROWS)) || (req_j > 8'(COLS));

  // Neighbour coordinates of the slot being issued; i,j >= 1 is guaranteed once accepted.
  always_comb begin
    nb_r = (slot == 2'd2) ? cell_i : cell_i - 8'd1;
    nb_c = (slot == 2'd1) ? cell_j : cell_j - 8'd1;
    nb_boundary = (nb_r == 8'd0) || (nb_c == 8'd0);
    if (nb_r == 8'd0)
      nb_value = W'(-(int'(nb_c) * GAP));
    else
      nb_value = W'(-(int'(nb_r) * GAP));
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rd_en     = 1'b0;
    rd_addr   = '0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid && !req_bad)
          state_nxt = ISSUE;
      end
      ISSUE: begin
        if (!nb_boundary) begin
          rd_en   = 1'b1;
          rd_addr = ADDR_W'(int'(nb_r) * (COLS + 1) + int'(nb_c));
        end
        if (slot == 2'd2)
          state_nxt = WAIT;
      end
      WAIT: begin
        if (wait_cnt == '0)
          state_nxt = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    diag = out_valid ? slot_buf[0] : SENTINEL;
    up   = out_valid ? slot_buf[1] : SENTINEL;
    left = out_valid ? slot_buf[2] : SENTINEL;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cell_i   <= '0;
      cell_j   <= '0;
      slot     <= '0;
      wait_cnt <= '0;
      err      <= 1'b0;
      for (int s = 0; s < 3; s++)
        slot_buf[s] <= SENTINEL;
      for (int k = 0; k < RAM_LAT; k++) begin
        tag_v[k]    <= 1'b0;
        tag_slot[k] <= '0;
      end
    end else begin
      err <= (state == IDLE) && req_valid && req_bad;
      if ((state == IDLE) && req_valid && !req_bad) begin
        cell_i <= req_i;
        cell_j <= req_j;
        slot   <= '0;
      end
      if (state == ISSUE) begin
        slot <= slot + 2'd1;
        if (slot == 2'd2)
          wait_cnt <= WC_W'(RAM_LAT - 1);
        if (nb_boundary)
          slot_buf[slot] <= nb_value;
      end
      if ((state == WAIT) && (wait_cnt != '0))
        wait_cnt <= wait_cnt - 1'b1;

      // Tag pipeline mirrors the RAM latency so returning data lands in the right slot.
      tag_v[0]    <= rd_en;
      tag_slot[0] <= slot;
      for (int k = 1; k < RAM_LAT; k++) begin
        tag_v[k]    <= tag_v[k-1];
        tag_slot[k] <= tag_slot[k-1];
      end
      if (tag_v[RAM_LAT-1])
        slot_buf[tag_slot[RAM_LAT-1]] <= rd_data;
    end
  end

endmodule
